cache_way_sel2: RTL and testbench

CACHE_WAY_SEL2 -- requirements
Module: cache_way_sel2

---
 rtl/cache_way_sel2.sv | 170 +++++++++++++++++
 tb/tb_cache_way_sel2.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cache_way_sel2.sv
// rtl/cache_way_sel2.sv - 2-way set-associative tag lookup with LRU replacement
// driving a downstream way selector through a drive/free handshake.
module cache_way_sel2 #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 20,
  parameter int TMO   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             flush,
  output logic             o_drive,
  input  logic             i_free,
  output logic             valid0,
  output logic             valid1,
  output logic             o_hit,
  output logic             o_tmo
);

  localparam int CNT_W = $clog2(TMO + 1);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);

  typedef enum logic [1:0] {IDLE, LOOKUP, DRIVE, WAIT_FREE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TAG_W-1:0]   r_tag0 [SETS];
  logic [TAG_W-1:0]   r_tag1 [SETS];
  logic [SETS-1:0]    r_vld0;
  logic [SETS-1:0]    r_vld1;
  logic [SETS-1:0]    r_lru;
  logic [TAG_W-1:0]   r_req_tag;
  logic [IDX_W-1:0]   r_req_idx;
  logic               r_v0;
  logic               r_v1;
  logic               r_hit;
  logic               r_tmo;
  logic               r_flush_pend;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_flush_now;
  logic               w_free_evt;
  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_sel;

  assign w_accept    = req_valid & req_ready;
  assign w_flush_now = (r_state == IDLE) & (flush | r_flush_pend);
  assign w_free_evt  = r_sync2 & ~r_sync3;
  assign w_hit0      = r_vld0[r_req_idx] & (r_tag0[r_req_idx] == r_req_tag);
  assign w_hit1      = r_vld1[r_req_idx] & (r_tag1[r_req_idx] == r_req_tag);
  assign w_hit       = w_hit0 | w_hit1;

  // Victim choice on a miss: first invalid way, otherwise the LRU pointer.
  always_comb begin
    w_sel = 1'b0;
    if (w_hit0)                  w_sel = 1'b0;
    else if (w_hit1)             w_sel = 1'b1;
    else if (!r_vld0[r_req_idx]) w_sel = 1'b0;
    else if (!r_vld1[r_req_idx]) w_sel = 1'b1;
    else                         w_sel = r_lru[r_req_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = LOOKUP;
      LOOKUP:    w_next = DRIVE;
      DRIVE:     w_next = WAIT_FREE;
      WAIT_FREE: if (w_free_evt) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    o_drive   = (r_state == DRIVE);
    req_ready = rst & (r_state == IDLE) & ~r_flush_pend & ~flush;
  end

  assign valid0 = r_v0;
  assign valid1 = r_v1;
  assign o_hit  = r_hit;
  assign o_tmo  = r_tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld0       <= '0;
      r_vld1       <= '0;
      r_lru        <= '0;
      r_req_tag    <= '0;
      r_req_idx    <= '0;
      r_v0         <= 1'b0;
      r_v1         <= 1'b0;
      r_hit        <= 1'b0;
      r_tmo        <= 1'b0;
      r_flush_pend <= 1'b0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_sync1 <= i_free;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;

      if (w_accept) begin
        r_req_tag <= req_tag;
        r_req_idx <= req_idx;
      end

      // Flushes outside IDLE are parked and replayed on the first IDLE cycle.
      if (w_flush_now) begin
        r_vld0       <= '0;
        r_vld1       <= '0;
        r_lru        <= '0;
        r_flush_pend <= 1'b0;
      end else if (flush) begin
        r_flush_pend <= 1'b1;
      end

      if (r_state == LOOKUP) begin
        r_v0             <= ~w_sel;
        r_v1             <= w_sel;
        r_hit            <= w_hit;
        r_lru[r_req_idx] <= ~w_sel;
        if (!w_hit) begin
          if (w_sel) r_vld1[r_req_idx] <= 1'b1;
          else       r_vld0[r_req_idx] <= 1'b1;
        end
      end

      if ((r_state == WAIT_FREE) && w_free_evt) begin
        r_v0  <= 1'b0;
        r_v1  <= 1'b0;
        r_hit <= 1'b0;
      end

      if (r_state == DRIVE)
        r_cnt <= '0;
      else if ((r_state == WAIT_FREE) && (r_cnt != TMO_C))
        r_cnt <= r_cnt + CNT_W'(1);

      if ((r_state == WAIT_FREE) && (r_cnt == TMO_C))
        r_tmo <= 1'b1;
    end
  end

  // Tag storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if ((r_state == LOOKUP) && !w_hit) begin
      if (w_sel) r_tag1[r_req_idx] <= r_req_tag;
      else       r_tag0[r_req_idx] <= r_req_tag;
    end
  end

endmodule

// File: tb/tb_cache_way_sel2.sv
// tb/tb_cache_way_sel2.sv - directed scoreboard bench for cache_way_sel2.
module tb_cache_way_sel2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [19:0] req_tag = '0;
  logic [3:0]  req_idx = '0;
  logic        flush = 1'b0;
  logic        o_drive;
  logic        i_free = 1'b0;
  logic        valid0;
  logic        valid1;
  logic        o_hit;
  logic        o_tmo;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [2:0]  exp_q[$];

  cache_way_sel2 #(.SETS(16), .IDX_W(4), .TAG_W(20), .TMO(255)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_idx(req_idx), .flush(flush), .o_drive(o_drive),
    .i_free(i_free), .valid0(valid0), .valid1(valid1), .o_hit(o_hit), .o_tmo(o_tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // exp = {valid0, valid1, o_hit} expected in the DRIVE cycle.
  task automatic send_req(input logic [19:0] t, input logic [3:0] i, input logic [2:0] exp);
    int n;
    logic [2:0] e;
    exp_q.push_back(exp);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_tag   = t;
    req_idx   = i;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!o_drive && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("drive_latency", n, 32'd2);
    e = exp_q.pop_front();
    check("sel_hit", {29'd0, valid0, valid1, o_hit}, {29'd0, e});
    @(negedge clk);
    check("drive_one_cycle", {31'd0, o_drive}, 32'd0);
    check("sel_hold", {29'd0, valid0, valid1, o_hit}, {29'd0, e});
  endtask

  task automatic free_rise();
    int n;
    i_free = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((valid0 | valid1) && n < 8);
    check("free_clear_cycles", n, 32'd3);
    check("free_clear_outs", {30'd0, valid0 | valid1, o_hit}, 32'd0);
  endtask

  task automatic free_low();
    i_free = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    check("reset_outs", {27'd0, o_drive, valid0, valid1, o_hit, o_tmo}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);

    // Cold miss, hit, second-way fill, LRU eviction, re-miss.
    send_req(20'h12345, 4'd3, 3'b100); free_rise(); free_low();
    send_req(20'h12345, 4'd3, 3'b101); free_rise(); free_low();
    send_req(20'h00ABC, 4'd3, 3'b010); free_rise(); free_low();
    send_req(20'h0F0F0, 4'd3, 3'b100); free_rise(); free_low();
    send_req(20'h12345, 4'd3, 3'b010); free_rise(); free_low();

    // Timeout while waiting, plus flush recorded during WAIT_FREE.
    send_req(20'h00001, 4'd5, 3'b100);
    repeat (250) @(negedge clk);
    check("tmo_early", {31'd0, o_tmo}, 32'd0);
    repeat (10) @(negedge clk);
    check("tmo_set", {31'd0, o_tmo}, 32'd1);
    check("tmo_valid_held", {30'd0, valid0, valid1}, 32'd2);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    @(negedge clk);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    free_rise();
    check("flush_idle_block", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("flush_idle_release", {31'd0, req_ready}, 32'd1);
    check("tmo_sticky", {31'd0, o_tmo}, 32'd1);
    free_low();
    send_req(20'h12345, 4'd3, 3'b100); free_rise(); free_low();

    // Flush in IDLE coinciding with a request.
    send_req(20'h0BEEF, 4'd7, 3'b100); free_rise(); free_low();
    send_req(20'h0BEEF, 4'd7, 3'b101); free_rise(); free_low();
    flush = 1'b1; req_valid = 1'b1; req_tag = 20'h0BEEF; req_idx = 4'd7;
    #1;
    check("flush_beats_req", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("flush_no_accept", {30'd0, o_drive, valid0}, 32'd0);
    send_req(20'h0BEEF, 4'd7, 3'b100); free_rise(); free_low();

    // Asynchronous reset during DRIVE.
    req_valid = 1'b1; req_tag = 20'h11111; req_idx = 4'd1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_drive", {31'd0, o_drive}, 32'd1);
    #1 rst = 1'b0;
    #1;
    check("async_reset_outs",
          {26'd0, o_drive, valid0, valid1, o_hit, o_tmo, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_drive) nd++;
    end
    check("no_drive_after_reset", nd, 32'd0);
    send_req(20'h11111, 4'd1, 3'b100); free_rise(); free_low();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
